// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: d = x - y - bin, with borrow-out.
// Purely combinational; the serial datapath registers around it.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor (diff = a - b, LSB first) with start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    state_t state, next_state;

    logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_next;
    logic [CNT_W-1:0] cnt;
    logic             bin_q;
    logic             cell_d, cell_bout;
    logic             last_bit;

    full_subtractor u_cell (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (bin_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign res_next = {cell_d, res_sh[WIDTH-1:1]};
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign busy     = (state == ST_RUN);
    assign done     = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start)    next_state = ST_RUN;
            ST_RUN:  if (last_bit) next_state = ST_DONE;
            ST_DONE:               next_state = ST_IDLE;
            default:               next_state = ST_IDLE;
        endcase
    end

    // Outputs are only written on the final RUN edge so they never show partial results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            bin_q  <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        res_sh <= '0;
                        bin_q  <= 1'b0;
                        cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    bin_q  <= cell_bout;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        diff   <= res_next;
                        borrow <= cell_bout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb, b_msb;

    // Operand sign bits are shifted out during RUN, so they are kept separately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
            end
            if (state == ST_RUN && last_bit) begin
                ovf <= (a_msb != b_msb) && (cell_d != a_msb);
            end
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
// Inputs change and outputs are sampled 1 ns after rising edges or on falling edges.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
`endif

    int checks_run;
    int fail_count;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, required finish before 200000 ns");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_run++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Starts one operation and watches 20 cycles after acceptance.
    // If repulse_at > 0, start is re-pulsed with new operands that many cycles into RUN.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input int repulse_at,
                                 output int latency, output int busy_cycles, output int done_pulses);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        latency = -1;
        done_pulses = 0;
        busy_cycles = busy ? 1 : 0;
        for (int k = 1; k <= 20; k++) begin
            if (repulse_at > 0 && k == repulse_at) begin
                a = 8'h55;
                b = 8'h22;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (busy) busy_cycles++;
            if (done) begin
                done_pulses++;
                if (latency < 0) latency = k;
            end
        end
        start = 1'b0;
    endtask

    int lat, bc, dp;

    initial begin
        checks_run = 0;
        fail_count = 0;
        rst = 1'b0;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;

        // Reset held for 3 cycles, then idle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("reset_busy", {31'd0, busy}, 32'd0);
            checkOutput("reset_done", {31'd0, done}, 32'd0);
            checkOutput("reset_diff", {24'd0, diff}, 32'd0);
            checkOutput("reset_borrow", {31'd0, borrow}, 32'd0);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("idle_busy", {31'd0, busy}, 32'd0);
            checkOutput("idle_done", {31'd0, done}, 32'd0);
        end

        // 10 - 3
        applyStimulus(8'd10, 8'd3, 0, lat, bc, dp);
        checkOutput("op1_latency", lat, 32'd8);
        checkOutput("op1_busy_cycles", bc, 32'd8);
        checkOutput("op1_done_pulses", dp, 32'd1);
        checkOutput("op1_diff", {24'd0, diff}, 32'd7);
        checkOutput("op1_borrow", {31'd0, borrow}, 32'd0);

        // 3 - 10
        applyStimulus(8'd3, 8'd10, 0, lat, bc, dp);
        checkOutput("op2_latency", lat, 32'd8);
        checkOutput("op2_diff", {24'd0, diff}, 32'hF9);
        checkOutput("op2_borrow", {31'd0, borrow}, 32'd1);

        // Equal operands
        applyStimulus(8'hFF, 8'hFF, 0, lat, bc, dp);
        checkOutput("op3_diff", {24'd0, diff}, 32'd0);
        checkOutput("op3_borrow", {31'd0, borrow}, 32'd0);

        // 0 - 1 wraps
        applyStimulus(8'h00, 8'h01, 0, lat, bc, dp);
        checkOutput("op4_diff", {24'd0, diff}, 32'hFF);
        checkOutput("op4_borrow", {31'd0, borrow}, 32'd1);
        checkOutput("op4_done_pulses", dp, 32'd1);

        // Start re-pulsed 3 cycles into RUN with 0x55/0x22 is ignored
        applyStimulus(8'd100, 8'd58, 3, lat, bc, dp);
        checkOutput("repulse_done_pulses", dp, 32'd1);
        checkOutput("repulse_latency", lat, 32'd8);
        checkOutput("repulse_diff", {24'd0, diff}, 32'd42);
        checkOutput("repulse_borrow", {31'd0, borrow}, 32'd0);

        // Reset 4 cycles into RUN: outputs clear immediately, no done follows
        @(negedge clk);
        a = 8'd10;
        b = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_done", {31'd0, done}, 32'd0);
        checkOutput("midrst_diff", {24'd0, diff}, 32'd0);
        checkOutput("midrst_borrow", {31'd0, borrow}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        dp = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) dp++;
        end
        checkOutput("midrst_no_activity", dp, 32'd0);
        checkOutput("midrst_diff_held", {24'd0, diff}, 32'd0);

        applyStimulus(8'd20, 8'd5, 0, lat, bc, dp);
        checkOutput("postrst_diff", {24'd0, diff}, 32'd15);
        checkOutput("postrst_borrow", {31'd0, borrow}, 32'd0);
        checkOutput("postrst_latency", lat, 32'd8);

`ifdef SERIAL_SUB_OVF_EN
        applyStimulus(8'h80, 8'h01, 0, lat, bc, dp);
        checkOutput("ovf1_diff", {24'd0, diff}, 32'h7F);
        checkOutput("ovf1_ovf", {31'd0, ovf}, 32'd1);
        checkOutput("ovf1_borrow", {31'd0, borrow}, 32'd0);
        applyStimulus(8'h05, 8'h03, 0, lat, bc, dp);
        checkOutput("ovf2_diff", {24'd0, diff}, 32'h02);
        checkOutput("ovf2_ovf", {31'd0, ovf}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks_run, fail_count);
        $finish;
    end

endmodule
